stack_pointer_unit: RTL and testbench

- Parametrised successor to the stack-cache pointer tracker; owns stack pointer (SP), upper/lower bounds, growth direction and PrePop meta for one stack context.
- Checks bounds on push and pop, and flags line spill/fill events to the stack-cache line engine.
- Keeps a CHECKPOINT_DEPTH-deep LIFO of SP checkpoints for nested speculation, with commit and mispredict rollback.
- Sits between the stack-cache controller and the CSR file.

---
 rtl/stack_pointer_unit_if.sv | 56 +++++
 rtl/stack_pointer_unit.sv | 197 +++++++++++++++++++
 tb/tb_stack_pointer_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pointer_unit_if.sv
// Bus between the stack-cache controller (master) and stack_pointer_unit (slave).
// Carries the CSR port, the push/pop handshake, and the speculation controls,
// together with every status output of the unit.
//   CSRAddr/CSRWriteEnable/CSRDataIn -> CSR access; CSRDataOut/CSRWriteStall back
//   PushEnable/PopEnable             -> element ops; PushAck/PopAck/errors/spill/fill back
//   SpecStart/SpecCommit/SpecMispredict -> checkpoint LIFO; CheckpointCount/Full back
interface stack_pointer_unit_if #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int CHECKPOINT_DEPTH = 4
);
    localparam int CW = $clog2(CHECKPOINT_DEPTH + 1);

    logic [1:0]                  CSRAddr;
    logic                        CSRWriteEnable;
    logic [ADDRESS_BITWIDTH-1:0] CSRDataIn;
    logic [ADDRESS_BITWIDTH-1:0] CSRDataOut;
    logic                        CSRWriteStall;

    logic                        PushEnable;
    logic                        PopEnable;
    logic                        PushAck;
    logic                        PopAck;
    logic                        OverflowError;
    logic                        UnderflowError;
    logic                        SpillPulse;
    logic                        FillPulse;
    logic [ADDRESS_BITWIDTH-1:0] CurrentStackPointer;
    logic                        PrePopEnable;
    logic                        GrowUp;

    logic                        SpecStart;
    logic                        SpecCommit;
    logic                        SpecMispredict;
    logic [CW-1:0]               CheckpointCount;
    logic                        CheckpointFull;

    modport master (
        output CSRAddr, CSRWriteEnable, CSRDataIn,
               PushEnable, PopEnable,
               SpecStart, SpecCommit, SpecMispredict,
        input  CSRDataOut, CSRWriteStall,
               PushAck, PopAck, OverflowError, UnderflowError,
               SpillPulse, FillPulse, CurrentStackPointer, PrePopEnable, GrowUp,
               CheckpointCount, CheckpointFull
    );

    modport slave (
        input  CSRAddr, CSRWriteEnable, CSRDataIn,
               PushEnable, PopEnable,
               SpecStart, SpecCommit, SpecMispredict,
        output CSRDataOut, CSRWriteStall,
               PushAck, PopAck, OverflowError, UnderflowError,
               SpillPulse, FillPulse, CurrentStackPointer, PrePopEnable, GrowUp,
               CheckpointCount, CheckpointFull
    );
endinterface

// File: rtl/stack_pointer_unit.sv
// Stack pointer tracker for one stack-cache context.
// Owns SP, upper/lower bounds, growth direction, PrePop and sticky error bits;
// bound-checks push/pop, flags line spill/fill crossings, and keeps a LIFO of
// SP checkpoints for nested speculation (commit / mispredict rollback).
// Ports:
//   clk          clock
//   async_rst_n  asynchronous active-low reset
//   clk_en       global enable; low freezes all state and silences all pulses
//   bus          stack_pointer_unit_if.slave (CSR, push/pop, speculation, status)
module stack_pointer_unit #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int LINESIZE         = 8,
    parameter int CHECKPOINT_DEPTH = 4
) (
    input  logic clk,
    input  logic async_rst_n,
    input  logic clk_en,
    stack_pointer_unit_if.slave bus
);
    localparam int AW = ADDRESS_BITWIDTH;
    localparam int L  = $clog2(LINESIZE);
    localparam int CW = $clog2(CHECKPOINT_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(CHECKPOINT_DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0] SP_ONE     = AW'(1);

    logic [AW-1:0] sp;
    logic [AW-1:0] upper;
    logic [AW-1:0] lower;
    logic          grow_up;
    logic          pre_pop;
    logic          sticky_ovf;
    logic          sticky_udf;
    logic [CW-1:0] count;
    // ckpt[0] is always the top of the LIFO; entries shift on push/pop
    logic [AW-1:0] ckpt [CHECKPOINT_DEPTH];

    logic          spec_active;
    logic          write_go;
    logic          sp_write;
    logic          meta_write;
    logic          mispredict;
    logic          ops_live;
    logic          push_valid;
    logic          pop_valid;
    logic          push_ack;
    logic          pop_ack;
    logic          ovf_err;
    logic          udf_err;
    logic          lone_push;
    logic          lone_pop;
    logic          spill;
    logic          fill;
    logic          start;
    logic          commit;
    logic [L-1:0]  line_off;
    logic [AW-1:0] next_sp;
    logic [AW-1:0] meta;

    always_comb begin
        spec_active = (count != '0);
        write_go    = bus.CSRWriteEnable & clk_en & ~spec_active;
        sp_write    = write_go & (bus.CSRAddr == 2'b11);
        meta_write  = write_go & (bus.CSRAddr == 2'b00);
        mispredict  = bus.SpecMispredict & clk_en & spec_active;
        // A rollback or a direct SP write takes the SP path this cycle, so the
        // element ops are dropped silently (no ack, no error).
        ops_live    = clk_en & ~mispredict & ~sp_write;

        push_valid  = grow_up ? (sp != upper) : (sp != lower);
        pop_valid   = grow_up ? (sp != lower) : (sp != upper);

        push_ack = 1'b0;
        pop_ack  = 1'b0;
        ovf_err  = 1'b0;
        udf_err  = 1'b0;
        if (ops_live) begin
            if (bus.PushEnable && bus.PopEnable) begin
                // Top replace: only the pop side can be out of range.
                if (pop_valid) begin
                    push_ack = 1'b1;
                    pop_ack  = 1'b1;
                end else begin
                    udf_err = 1'b1;
                end
            end else if (bus.PushEnable) begin
                push_ack = push_valid;
                ovf_err  = ~push_valid;
            end else if (bus.PopEnable) begin
                pop_ack = pop_valid;
                udf_err = ~pop_valid;
            end
        end

        lone_push = push_ack & ~pop_ack;
        lone_pop  = pop_ack & ~push_ack;
        line_off  = sp[L-1:0];
        spill     = lone_push & (grow_up ? (line_off == '1) : (line_off == '0));
        fill      = lone_pop  & (grow_up ? (line_off == '0) : (line_off == '1));

        next_sp = sp;
        if (mispredict) begin
            next_sp = ckpt[0];
        end else if (sp_write) begin
            next_sp = bus.CSRDataIn;
        end else if (lone_push) begin
            next_sp = grow_up ? (sp + SP_ONE) : (sp - SP_ONE);
        end else if (lone_pop) begin
            next_sp = grow_up ? (sp - SP_ONE) : (sp + SP_ONE);
        end

        start  = bus.SpecStart  & clk_en & ~mispredict;
        commit = bus.SpecCommit & clk_en & ~mispredict;

        meta    = '0;
        meta[0] = grow_up;
        meta[1] = pre_pop;
        meta[8] = sticky_ovf;
        meta[9] = sticky_udf;
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sp         <= '0;
            upper      <= '0;
            lower      <= '0;
            grow_up    <= 1'b0;
            pre_pop    <= 1'b0;
            sticky_ovf <= 1'b0;
            sticky_udf <= 1'b0;
            count      <= '0;
            for (int unsigned i = 0; i < CHECKPOINT_DEPTH; i++) begin
                ckpt[i] <= '0;
            end
        end else if (clk_en) begin
            sp <= next_sp;

            if (write_go) begin
                case (bus.CSRAddr)
                    2'b00: begin
                        grow_up <= bus.CSRDataIn[0];
                        pre_pop <= bus.CSRDataIn[1];
                    end
                    2'b01:   upper <= bus.CSRDataIn;
                    2'b10:   lower <= bus.CSRDataIn;
                    default: ;
                endcase
            end

            // Write-1-to-clear, with a same-cycle set taking precedence.
            sticky_ovf <= (sticky_ovf & ~(meta_write & bus.CSRDataIn[8])) | ovf_err;
            sticky_udf <= (sticky_udf & ~(meta_write & bus.CSRDataIn[9])) | udf_err;

            if (mispredict) begin
                for (int unsigned i = 0; i + 1 < CHECKPOINT_DEPTH; i++) begin
                    ckpt[i] <= ckpt[i+1];
                end
                count <= count - COUNT_ONE;
            end else if (start && commit && spec_active) begin
                ckpt[0] <= next_sp;
            end else if (commit && spec_active) begin
                for (int unsigned i = 0; i + 1 < CHECKPOINT_DEPTH; i++) begin
                    ckpt[i] <= ckpt[i+1];
                end
                count <= count - COUNT_ONE;
            end else if (start && (count != FULL_COUNT)) begin
                for (int unsigned i = 1; i < CHECKPOINT_DEPTH; i++) begin
                    ckpt[i] <= ckpt[i-1];
                end
                ckpt[0] <= next_sp;
                count   <= count + COUNT_ONE;
            end
        end
    end

    always_comb begin
        case (bus.CSRAddr)
            2'b00:   bus.CSRDataOut = meta;
            2'b01:   bus.CSRDataOut = upper;
            2'b10:   bus.CSRDataOut = lower;
            default: bus.CSRDataOut = sp;
        endcase
    end

    assign bus.CSRWriteStall       = bus.CSRWriteEnable & clk_en & spec_active;
    assign bus.PushAck             = push_ack;
    assign bus.PopAck              = pop_ack;
    assign bus.OverflowError       = ovf_err;
    assign bus.UnderflowError      = udf_err;
    assign bus.SpillPulse          = spill;
    assign bus.FillPulse           = fill;
    assign bus.CurrentStackPointer = sp;
    assign bus.PrePopEnable        = pre_pop;
    assign bus.GrowUp              = grow_up;
    assign bus.CheckpointCount     = count;
    assign bus.CheckpointFull      = (count == FULL_COUNT);
endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit: expectations are queued as stimulus is
// driven and drained against the DUT at the sampling point that follows.
module tb_stack_pointer_unit;
    localparam int AW = 32;
    localparam int LS = 8;
    localparam int D  = 4;

    localparam int O_SP    = 0;
    localparam int O_CSR   = 1;
    localparam int O_PUSH  = 2;
    localparam int O_POP   = 3;
    localparam int O_OVF   = 4;
    localparam int O_UDF   = 5;
    localparam int O_SPILL = 6;
    localparam int O_FILL  = 7;
    localparam int O_CNT   = 8;
    localparam int O_FULL  = 9;
    localparam int O_STALL = 10;
    localparam int O_GROW  = 11;

    logic clk;
    logic rst_n;
    logic clk_en;

    stack_pointer_unit_if #(.ADDRESS_BITWIDTH(AW), .CHECKPOINT_DEPTH(D)) bus ();

    stack_pointer_unit #(
        .ADDRESS_BITWIDTH(AW),
        .LINESIZE(LS),
        .CHECKPOINT_DEPTH(D)
    ) dut (
        .clk(clk),
        .async_rst_n(rst_n),
        .clk_en(clk_en),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            O_SP:    return bus.CurrentStackPointer;
            O_CSR:   return bus.CSRDataOut;
            O_PUSH:  return 32'(bus.PushAck);
            O_POP:   return 32'(bus.PopAck);
            O_OVF:   return 32'(bus.OverflowError);
            O_UDF:   return 32'(bus.UnderflowError);
            O_SPILL: return 32'(bus.SpillPulse);
            O_FILL:  return 32'(bus.FillPulse);
            O_CNT:   return 32'(bus.CheckpointCount);
            O_FULL:  return 32'(bus.CheckpointFull);
            O_STALL: return 32'(bus.CSRWriteStall);
            O_GROW:  return 32'(bus.GrowUp);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic want(input int sel, input logic [31:0] val, input string tag);
        exp_t e;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sel);
            tests++;
            assert (o === e.val) else begin
                fails++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic idle();
        bus.CSRAddr        = 2'b00;
        bus.CSRWriteEnable = 1'b0;
        bus.CSRDataIn      = '0;
        bus.PushEnable     = 1'b0;
        bus.PopEnable      = 1'b0;
        bus.SpecStart      = 1'b0;
        bus.SpecCommit     = 1'b0;
        bus.SpecMispredict = 1'b0;
    endtask

    task automatic settle();
        #1;
        check();
    endtask

    task automatic clock_in();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.CSRAddr        = addr;
        bus.CSRDataIn      = data;
        bus.CSRWriteEnable = 1'b1;
        clock_in();
    endtask

    task automatic csr_read(input logic [1:0] addr, input logic [31:0] val, input string tag);
        @(negedge clk);
        bus.CSRAddr = addr;
        want(O_CSR, val, tag);
        settle();
    endtask

    task automatic ops(input logic push, input logic pop);
        @(negedge clk);
        bus.PushEnable = push;
        bus.PopEnable  = pop;
    endtask

    initial begin
        idle();
        clk_en = 1'b1;
        rst_n  = 1'b0;

        #2;
        want(O_SP, 32'h0, "rst_sp");
        want(O_CNT, 32'h0, "rst_cnt");
        want(O_FULL, 32'h0, "rst_full");
        want(O_CSR, 32'h0, "rst_meta");
        want(O_PUSH, 32'h0, "rst_pushack");
        want(O_OVF, 32'h0, "rst_ovf");
        check();
        @(negedge clk);
        rst_n = 1'b1;

        csr_write(2'b01, 32'h108);
        csr_write(2'b10, 32'h100);
        csr_write(2'b11, 32'h108);
        csr_read(2'b11, 32'h108, "rd_sp");
        csr_read(2'b01, 32'h108, "rd_upper");
        csr_read(2'b10, 32'h100, "rd_lower");
        want(O_CNT, 32'h0, "cnt_idle");
        check();

        // clk_en low: no ack, no error, SP frozen
        ops(1'b1, 1'b0);
        clk_en = 1'b0;
        want(O_PUSH, 32'h0, "gated_pushack");
        want(O_OVF, 32'h0, "gated_ovf");
        settle();
        clock_in();
        clk_en = 1'b1;
        want(O_SP, 32'h108, "gated_sp");
        check();

        for (int k = 0; k < 8; k++) begin
            ops(1'b1, 1'b0);
            want(O_PUSH, 32'h1, "push_ack");
            want(O_OVF, 32'h0, "push_ovf");
            want(O_SPILL, 32'(k == 0), "push_spill");
            settle();
            clock_in();
            want(O_SP, 32'h107 - 32'(k), "push_sp");
            check();
        end

        ops(1'b1, 1'b0);
        want(O_PUSH, 32'h0, "push9_ack");
        want(O_OVF, 32'h1, "push9_ovf");
        want(O_SPILL, 32'h0, "push9_spill");
        settle();
        clock_in();
        want(O_SP, 32'h100, "push9_sp");
        check();
        csr_read(2'b00, 32'h100, "sticky_ovf_set");
        csr_write(2'b00, 32'h100);
        csr_read(2'b00, 32'h000, "sticky_ovf_clr");

        ops(1'b0, 1'b1);
        want(O_POP, 32'h1, "pop_ack");
        want(O_FILL, 32'h0, "pop_nofill");
        settle();
        clock_in();
        want(O_SP, 32'h101, "pop_sp");
        check();

        csr_write(2'b11, 32'h107);
        ops(1'b0, 1'b1);
        want(O_POP, 32'h1, "fill_ack");
        want(O_FILL, 32'h1, "fill_pulse");
        settle();
        clock_in();
        want(O_SP, 32'h108, "fill_sp");
        check();

        ops(1'b0, 1'b1);
        want(O_POP, 32'h0, "popub_ack");
        want(O_UDF, 32'h1, "popub_udf");
        settle();
        clock_in();
        want(O_SP, 32'h108, "popub_sp");
        check();
        csr_read(2'b00, 32'h200, "sticky_udf_set");

        csr_write(2'b11, 32'h104);
        ops(1'b1, 1'b1);
        want(O_PUSH, 32'h1, "repl_pushack");
        want(O_POP, 32'h1, "repl_popack");
        want(O_SPILL, 32'h0, "repl_spill");
        want(O_FILL, 32'h0, "repl_fill");
        settle();
        clock_in();
        want(O_SP, 32'h104, "repl_sp");
        check();

        csr_write(2'b11, 32'h108);
        ops(1'b1, 1'b1);
        want(O_PUSH, 32'h0, "replbad_pushack");
        want(O_POP, 32'h0, "replbad_popack");
        want(O_UDF, 32'h1, "replbad_udf");
        want(O_OVF, 32'h0, "replbad_ovf");
        settle();
        clock_in();
        want(O_SP, 32'h108, "replbad_sp");
        check();

        // grow-up direction
        csr_write(2'b00, 32'h001);
        csr_write(2'b11, 32'h100);
        want(O_GROW, 32'h1, "growup_bit");
        check();
        ops(1'b0, 1'b1);
        want(O_POP, 32'h0, "gu_pop_ack");
        want(O_UDF, 32'h1, "gu_pop_udf");
        settle();
        clock_in();
        want(O_SP, 32'h100, "gu_pop_sp");
        check();
        ops(1'b1, 1'b0);
        want(O_PUSH, 32'h1, "gu_push_ack");
        want(O_SPILL, 32'h0, "gu_push_spill");
        settle();
        clock_in();
        want(O_SP, 32'h101, "gu_push_sp");
        check();
        csr_read(2'b00, 32'h201, "gu_meta");

        csr_write(2'b11, 32'h107);
        ops(1'b1, 1'b0);
        want(O_PUSH, 32'h1, "gu_spill_ack");
        want(O_SPILL, 32'h1, "gu_spill");
        settle();
        clock_in();
        want(O_SP, 32'h108, "gu_spill_sp");
        check();
        ops(1'b0, 1'b1);
        want(O_POP, 32'h1, "gu_fill_ack");
        want(O_FILL, 32'h1, "gu_fill");
        settle();
        clock_in();
        want(O_SP, 32'h107, "gu_fill_sp");
        check();

        csr_write(2'b00, 32'h200);
        csr_read(2'b00, 32'h000, "meta_clr");

        // speculation with rollback
        csr_write(2'b11, 32'h104);
        @(negedge clk);
        bus.SpecStart  = 1'b1;
        bus.PushEnable = 1'b1;
        want(O_PUSH, 32'h1, "spec_push_ack");
        settle();
        clock_in();
        want(O_SP, 32'h103, "spec_sp");
        want(O_CNT, 32'h1, "spec_cnt");
        check();
        for (int k = 0; k < 2; k++) begin
            ops(1'b1, 1'b0);
            clock_in();
            want(O_SP, 32'h102 - 32'(k), "spec_push_sp");
            check();
        end
        @(negedge clk);
        bus.SpecMispredict = 1'b1;
        bus.PushEnable     = 1'b1;
        want(O_PUSH, 32'h0, "mis_pushack");
        want(O_OVF, 32'h0, "mis_ovf");
        settle();
        clock_in();
        want(O_SP, 32'h103, "mis_sp");
        want(O_CNT, 32'h0, "mis_cnt");
        check();

        // LIFO depth and CSR stall
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.SpecStart = 1'b1;
            clock_in();
            want(O_CNT, 32'((k < 4) ? k + 1 : 4), "fill_cnt");
            want(O_FULL, 32'(k >= 3), "fill_full");
            check();
        end
        @(negedge clk);
        bus.CSRAddr        = 2'b11;
        bus.CSRDataIn      = 32'h0;
        bus.CSRWriteEnable = 1'b1;
        want(O_STALL, 32'h1, "stall");
        settle();
        clock_in();
        want(O_SP, 32'h103, "stall_sp");
        check();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.SpecCommit = 1'b1;
            clock_in();
            want(O_CNT, 32'(3 - k), "commit_cnt");
            check();
        end
        @(negedge clk);
        bus.CSRAddr        = 2'b11;
        bus.CSRDataIn      = 32'h0;
        bus.CSRWriteEnable = 1'b1;
        want(O_STALL, 32'h0, "retry_stall");
        settle();
        clock_in();
        want(O_SP, 32'h0, "retry_sp");
        check();

        // asynchronous reset during speculation
        csr_write(2'b11, 32'h105);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.SpecStart = 1'b1;
            clock_in();
        end
        want(O_CNT, 32'h2, "pre_rst_cnt");
        check();
        @(negedge clk);
        bus.CSRAddr = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        want(O_SP, 32'h0, "arst_sp");
        want(O_CSR, 32'h0, "arst_csr");
        want(O_CNT, 32'h0, "arst_cnt");
        want(O_FULL, 32'h0, "arst_full");
        want(O_GROW, 32'h0, "arst_grow");
        want(O_PUSH, 32'h0, "arst_pushack");
        check();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
